// File: rtl/nios2_oci_arb_pkg.sv
// Shared types and default widths for the OCI debug-RAM access arbiter.
package nios2_oci_arb_pkg;

  localparam int unsigned ADDR_W_DEF = 8;
  localparam int unsigned DATA_W_DEF = 32;

  // Access sequencer: grant, strobe RAM, wait for read data, respond.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Which requester owns the access in flight.
  typedef enum logic {
    OWN_JTAG = 1'b0,
    OWN_AV   = 1'b1
  } owner_t;

endpackage

// File: rtl/nios2_oci_arb_jtag_port.sv
// JTAG side of the arbiter: auto-incrementing address register and a
// single-entry pending request with a sticky overrun flag.
module nios2_oci_arb_jtag_port
  import nios2_oci_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              addr_load,
  input  logic [ADDR_W-1:0] addr_in,
  input  logic              access,
  input  logic              write_in,
  input  logic [DATA_W-1:0] wdata_in,
  input  logic              inc,
  input  logic              clear,
  output logic [ADDR_W-1:0] addr,
  output logic              pend,
  output logic              write,
  output logic [DATA_W-1:0] wdata,
  output logic              overrun
);

  // Address register: an explicit load takes precedence over the increment.
  always_ff @(posedge clk) begin
    if (reset) begin
      addr <= '0;
    end else if (addr_load) begin
      addr <= addr_in;
    end else if (inc) begin
      addr <= addr + ADDR_W'(1);
    end
  end

  // Pending request capture; a strobe arriving while one is held is dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      pend    <= 1'b0;
      write   <= 1'b0;
      wdata   <= '0;
      overrun <= 1'b0;
    end else begin
      if (clear) begin
        pend <= 1'b0;
      end
      if (access) begin
        if (pend) begin
          overrun <= 1'b1;
        end else begin
          pend  <= 1'b1;
          write <= write_in;
          wdata <= wdata_in;
        end
      end
    end
  end

endmodule

// File: rtl/nios2_oci_access_arbiter.sv
// Shares the single-port OCI debug RAM between the JTAG command path and the
// CPU Avalon debug_mem slave. Each access runs IDLE->ISSUE->WAIT->DONE.
// Optional macro OCI_ARB_WPROT_EN: blocks Avalon writes at or above PROT_BASE
// while the CPU is not in debug mode and flags them on av_wprot_err.
module nios2_oci_access_arbiter
  import nios2_oci_arb_pkg::*;
#(
  parameter int unsigned       ADDR_W    = ADDR_W_DEF,
  parameter int unsigned       DATA_W    = DATA_W_DEF,
  parameter logic [ADDR_W-1:0] PROT_BASE = ADDR_W'(8'hE0)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  debugack,
  input  logic                  jtag_addr_load,
  input  logic [ADDR_W-1:0]     jtag_addr_in,
  input  logic                  jtag_access,
  input  logic                  jtag_write,
  input  logic [DATA_W-1:0]     jtag_wdata,
  output logic                  jtag_rsp_valid,
  output logic [DATA_W-1:0]     jtag_rsp_data,
  output logic                  jtag_overrun,
  input  logic [ADDR_W-1:0]     av_address,
  input  logic                  av_read,
  input  logic                  av_write,
  input  logic [DATA_W-1:0]     av_writedata,
  input  logic [DATA_W/8-1:0]   av_byteenable,
  output logic                  av_waitrequest,
  output logic [DATA_W-1:0]     av_readdata,
  output logic                  av_wprot_err,
  output logic                  ram_en,
  output logic                  ram_wren,
  output logic [ADDR_W-1:0]     ram_addr,
  output logic [DATA_W/8-1:0]   ram_byteenable,
  output logic [DATA_W-1:0]     ram_wdata,
  input  logic [DATA_W-1:0]     ram_rdata
);

  localparam int unsigned BE_W = DATA_W / 8;

`ifdef OCI_ARB_WPROT_EN
  localparam bit WPROT_EN = 1'b1;
`else
  localparam bit WPROT_EN = 1'b0;
`endif

  state_t              state;
  owner_t              owner;
  owner_t              last_owner;
  logic [DATA_W-1:0]   rdata;
  logic                wprot_err;

  logic [ADDR_W-1:0]   jtag_addr;
  logic                jtag_pend;
  logic                jtag_wr;
  logic [DATA_W-1:0]   jtag_wd;

  logic                av_req_c;
  logic                pick_jtag_c;
  logic                grant_write_c;
  logic                block_c;
  logic                jtag_inc_c;
  logic                jtag_clear_c;

  // JTAG address / pending request handling.
  nios2_oci_arb_jtag_port #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_jtag_port (
    .clk       (clk),
    .reset     (reset),
    .addr_load (jtag_addr_load),
    .addr_in   (jtag_addr_in),
    .access    (jtag_access),
    .write_in  (jtag_write),
    .wdata_in  (jtag_wdata),
    .inc       (jtag_inc_c),
    .clear     (jtag_clear_c),
    .addr      (jtag_addr),
    .pend      (jtag_pend),
    .write     (jtag_wr),
    .wdata     (jtag_wd),
    .overrun   (jtag_overrun)
  );

  // Arbitration: JTAG wins outright in debug mode, otherwise whoever did not
  // own the previous access.
  assign av_req_c      = av_read | av_write;
  assign pick_jtag_c   = jtag_pend & (~av_req_c | debugack | (last_owner == OWN_AV));
  assign grant_write_c = pick_jtag_c ? jtag_wr : av_write;
  assign block_c       = WPROT_EN & ~pick_jtag_c & av_write & ~debugack &
                         (av_address >= PROT_BASE);

  assign jtag_inc_c    = (state == ISSUE) & (owner == OWN_JTAG);
  assign jtag_clear_c  = (state == DONE) & (owner == OWN_JTAG);

  // Stall is combinational so the Avalon master sees release exactly in DONE.
  assign av_waitrequest = av_req_c & ~((state == DONE) & (owner == OWN_AV));
  assign av_readdata    = rdata;
  assign jtag_rsp_data  = rdata;
  assign av_wprot_err   = wprot_err;

  // Access sequencer with registered RAM strobes and responses.
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      owner          <= OWN_AV;
      last_owner     <= OWN_AV;
      ram_en         <= 1'b0;
      ram_wren       <= 1'b0;
      ram_addr       <= '0;
      ram_byteenable <= '0;
      ram_wdata      <= '0;
      rdata          <= '0;
      jtag_rsp_valid <= 1'b0;
      wprot_err      <= 1'b0;
    end else begin
      ram_en         <= 1'b0;
      ram_wren       <= 1'b0;
      jtag_rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (jtag_pend | av_req_c) begin
            owner          <= pick_jtag_c ? OWN_JTAG : OWN_AV;
            ram_addr       <= pick_jtag_c ? jtag_addr : av_address;
            ram_wdata      <= pick_jtag_c ? jtag_wd : av_writedata;
            ram_byteenable <= pick_jtag_c ? {BE_W{1'b1}} : av_byteenable;
            ram_en         <= 1'b1;
            ram_wren       <= grant_write_c & ~block_c;
            if (block_c) begin
              wprot_err <= 1'b1;
            end
            state <= ISSUE;
          end
        end
        ISSUE: begin
          state <= WAIT;
        end
        WAIT: begin
          rdata          <= ram_rdata;
          jtag_rsp_valid <= (owner == OWN_JTAG);
          state          <= DONE;
        end
        DONE: begin
          last_owner <= owner;
          state      <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nios2_oci_access_arbiter.sv
// Self-checking bench for nios2_oci_access_arbiter with a behavioural RAM and
// a scoreboard of expected RAM operations and JTAG responses.
module tb_nios2_oci_access_arbiter;

  localparam int unsigned AW = 8;
  localparam int unsigned DW = 32;
  localparam int unsigned BW = DW / 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          debugack;
  logic          jtag_addr_load;
  logic [AW-1:0] jtag_addr_in;
  logic          jtag_access;
  logic          jtag_write;
  logic [DW-1:0] jtag_wdata;
  logic          jtag_rsp_valid;
  logic [DW-1:0] jtag_rsp_data;
  logic          jtag_overrun;
  logic [AW-1:0] av_address;
  logic          av_read;
  logic          av_write;
  logic [DW-1:0] av_writedata;
  logic [BW-1:0] av_byteenable;
  logic          av_waitrequest;
  logic [DW-1:0] av_readdata;
  logic          av_wprot_err;
  logic          ram_en;
  logic          ram_wren;
  logic [AW-1:0] ram_addr;
  logic [BW-1:0] ram_byteenable;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [BW-1:0] be;
  } op_t;

  typedef struct {
    bit            chk;
    logic [DW-1:0] data;
  } rsp_t;

  op_t  exp_q[$];
  rsp_t rsp_q[$];

  logic [DW-1:0] mem [0:255];

  always #5 clk = ~clk;

  nios2_oci_access_arbiter dut (
    .clk            (clk),
    .reset          (reset),
    .debugack       (debugack),
    .jtag_addr_load (jtag_addr_load),
    .jtag_addr_in   (jtag_addr_in),
    .jtag_access    (jtag_access),
    .jtag_write     (jtag_write),
    .jtag_wdata     (jtag_wdata),
    .jtag_rsp_valid (jtag_rsp_valid),
    .jtag_rsp_data  (jtag_rsp_data),
    .jtag_overrun   (jtag_overrun),
    .av_address     (av_address),
    .av_read        (av_read),
    .av_write       (av_write),
    .av_writedata   (av_writedata),
    .av_byteenable  (av_byteenable),
    .av_waitrequest (av_waitrequest),
    .av_readdata    (av_readdata),
    .av_wprot_err   (av_wprot_err),
    .ram_en         (ram_en),
    .ram_wren       (ram_wren),
    .ram_addr       (ram_addr),
    .ram_byteenable (ram_byteenable),
    .ram_wdata      (ram_wdata),
    .ram_rdata      (ram_rdata)
  );

  function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
    return 32'hC0DE_0000 | {24'h0, a};
  endfunction

  function automatic op_t mk_op(input logic wr, input logic [AW-1:0] a,
                                input logic [DW-1:0] d, input logic [BW-1:0] be);
    op_t o;
    o.wr = wr; o.addr = a; o.wdata = d; o.be = be;
    return o;
  endfunction

  function automatic rsp_t mk_rsp(input bit chk, input logic [DW-1:0] d);
    rsp_t r;
    r.chk = chk; r.data = d;
    return r;
  endfunction

  // Single-port RAM, one-cycle read latency, old data on read-during-write.
  always @(posedge clk) begin
    if (ram_en === 1'b1) begin
      logic [DW-1:0] rd;
      rd = mem[ram_addr];
      ram_rdata <= rd;
      if (ram_wren === 1'b1) begin
        for (int b = 0; b < int'(BW); b++) begin
          if (ram_byteenable[b]) mem[ram_addr][8*b +: 8] = ram_wdata[8*b +: 8];
        end
      end
    end
  end

  // Scoreboard: pop expected RAM ops and JTAG responses as the DUT emits them.
  always @(negedge clk) begin
    if (reset === 1'b0) begin
      if (ram_en === 1'b1) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL ram_op: unexpected access wr=%b addr=%h, required none", ram_wren, ram_addr);
        end else begin
          op_t e;
          e = exp_q.pop_front();
          if (ram_addr !== e.addr || ram_wren !== e.wr || ram_byteenable !== e.be ||
              (e.wr && ram_wdata !== e.wdata)) begin
            bad++;
            $display("FAIL ram_op: got wr=%b addr=%h wdata=%h be=%h, required wr=%b addr=%h wdata=%h be=%h",
                     ram_wren, ram_addr, ram_wdata, ram_byteenable, e.wr, e.addr, e.wdata, e.be);
          end
        end
      end
      if (jtag_rsp_valid === 1'b1) begin
        total++;
        if (rsp_q.size() == 0) begin
          bad++;
          $display("FAIL jtag_rsp: unexpected response data=%h, required none", jtag_rsp_data);
        end else begin
          rsp_t r;
          r = rsp_q.pop_front();
          if (r.chk && jtag_rsp_data !== r.data) begin
            bad++;
            $display("FAIL jtag_rsp: got data=%h, required %h", jtag_rsp_data, r.data);
          end
        end
      end
    end
  end

  task automatic jtag_pulse(input bit ld, input logic [AW-1:0] a, input logic wr,
                            input logic [DW-1:0] d);
    @(negedge clk);
    jtag_addr_load = ld; jtag_addr_in = a;
    jtag_access = 1'b1; jtag_write = wr; jtag_wdata = d;
    @(negedge clk);
    jtag_addr_load = 1'b0; jtag_access = 1'b0;
  endtask

  task automatic wait_jrsp(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (jtag_rsp_valid === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Call at a negedge; returns k = cycles from drive to release.
  task automatic av_access(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                           input logic [BW-1:0] be, output bit ok, output int k,
                           output logic [DW-1:0] rd);
    av_address = a; av_writedata = d; av_byteenable = be;
    av_write = wr; av_read = ~wr;
    ok = 1'b0; k = 0; rd = '0;
    while (k < 40) begin
      #1;
      if (av_waitrequest === 1'b0) begin
        ok = 1'b1;
        rd = av_readdata;
        break;
      end
      @(negedge clk);
      k++;
    end
    av_read = 1'b0; av_write = 1'b0;
  endtask

  task automatic check_drained(input string name);
    repeat (8) @(negedge clk);
    total++;
    if (exp_q.size() != 0 || rsp_q.size() != 0) begin
      bad++;
      $display("FAIL %s drained: got ops=%0d rsps=%0d left, required 0 0", name, exp_q.size(), rsp_q.size());
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; av_read = 1'b1; av_address = 8'h05;
    repeat (3) @(negedge clk);
    #1;
    total++;
    if (ram_en !== 1'b0 || ram_wren !== 1'b0 || jtag_rsp_valid !== 1'b0) begin
      bad++;
      $display("FAIL reset_strobes: got en=%b wren=%b rsp=%b, required 0 0 0", ram_en, ram_wren, jtag_rsp_valid);
    end
    total++;
    if (jtag_overrun !== 1'b0 || av_wprot_err !== 1'b0) begin
      bad++;
      $display("FAIL reset_flags: got overrun=%b wprot=%b, required 0 0", jtag_overrun, av_wprot_err);
    end
    total++;
    if (av_readdata !== 32'h0 || jtag_rsp_data !== 32'h0 || ram_addr !== 8'h00) begin
      bad++;
      $display("FAIL reset_data: got rd=%h jd=%h addr=%h, required 0 0 0", av_readdata, jtag_rsp_data, ram_addr);
    end
    total++;
    if (av_waitrequest !== 1'b1) begin
      bad++;
      $display("FAIL reset_waitreq: got %b, required 1", av_waitrequest);
    end
    av_read = 1'b0;
    #1;
    total++;
    if (av_waitrequest !== 1'b0) begin
      bad++;
      $display("FAIL idle_waitreq: got %b, required 0", av_waitrequest);
    end
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_jtag_write;
    bit ok;
    exp_q.push_back(mk_op(1'b1, 8'h10, 32'hDEADBEEF, 4'hF));
    rsp_q.push_back(mk_rsp(1'b0, '0));
    jtag_pulse(1'b1, 8'h10, 1'b1, 32'hDEADBEEF);
    total++;
    if (ram_en !== 1'b0) begin
      bad++;
      $display("FAIL jw_grant_cycle: got ram_en=%b, required 0", ram_en);
    end
    @(negedge clk);
    total++;
    if (ram_en !== 1'b1 || ram_wren !== 1'b1 || ram_addr !== 8'h10) begin
      bad++;
      $display("FAIL jw_issue: got en=%b wren=%b addr=%h, required 1 1 10", ram_en, ram_wren, ram_addr);
    end
    @(negedge clk);
    total++;
    if (jtag_rsp_valid !== 1'b0) begin
      bad++;
      $display("FAIL jw_rsp_early: got %b, required 0", jtag_rsp_valid);
    end
    @(negedge clk);
    total++;
    if (jtag_rsp_valid !== 1'b1) begin
      bad++;
      $display("FAIL jw_rsp_latency: got %b, required 1", jtag_rsp_valid);
    end
    @(negedge clk);
    total++;
    if (jtag_rsp_valid !== 1'b0) begin
      bad++;
      $display("FAIL jw_rsp_pulse: got %b, required 0", jtag_rsp_valid);
    end
    total++;
    if (mem[8'h10] !== 32'hDEADBEEF) begin
      bad++;
      $display("FAIL jw_mem: got %h, required deadbeef", mem[8'h10]);
    end
    // Address register must have advanced to 0x11.
    exp_q.push_back(mk_op(1'b0, 8'h11, '0, 4'hF));
    rsp_q.push_back(mk_rsp(1'b1, init_val(8'h11)));
    jtag_pulse(1'b0, 8'h00, 1'b0, '0);
    wait_jrsp(ok);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL jr_inc_timeout: got no response, required one");
    end
    check_drained("jtag_write");
  endtask

  task automatic test_av_read;
    exp_q.push_back(mk_op(1'b0, 8'h20, '0, 4'hF));
    @(negedge clk);
    av_address = 8'h20; av_byteenable = 4'hF; av_read = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      total++;
      if (av_waitrequest !== 1'b1) begin
        bad++;
        $display("FAIL av_stall cycle %0d: got %b, required 1", c, av_waitrequest);
      end
      @(negedge clk);
    end
    #1;
    total++;
    if (av_waitrequest !== 1'b0 || av_readdata !== 32'h12345678) begin
      bad++;
      $display("FAIL av_read_done: got wr=%b data=%h, required 0 12345678", av_waitrequest, av_readdata);
    end
    av_read = 1'b0;
    check_drained("av_read");
  endtask

  task automatic test_round_robin;
    bit ok; int k; logic [DW-1:0] rd;
    // JTAG pending meets a new Avalon write; last owner was Avalon.
    exp_q.push_back(mk_op(1'b0, 8'h12, '0, 4'hF));
    rsp_q.push_back(mk_rsp(1'b1, init_val(8'h12)));
    exp_q.push_back(mk_op(1'b1, 8'h30, 32'hA1B2C3D4, 4'b0101));
    jtag_pulse(1'b0, 8'h00, 1'b0, '0);
    av_access(1'b1, 8'h30, 32'hA1B2C3D4, 4'b0101, ok, k, rd);
    total++;
    if (!ok || k != 7) begin
      bad++;
      $display("FAIL rr_jtag_first: got ok=%b wait=%0d, required 1 7", ok, k);
    end
    check_drained("rr_round1");
    total++;
    if (mem[8'h30] !== 32'hC0B200D4) begin
      bad++;
      $display("FAIL rr_byteenable: got %h, required c0b200d4", mem[8'h30]);
    end
    // Lone JTAG access makes JTAG the last owner.
    exp_q.push_back(mk_op(1'b0, 8'h13, '0, 4'hF));
    rsp_q.push_back(mk_rsp(1'b1, init_val(8'h13)));
    jtag_pulse(1'b0, 8'h00, 1'b0, '0);
    wait_jrsp(ok);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL rr_lone_timeout: got no response, required one");
    end
    repeat (2) @(negedge clk);
    exp_q.push_back(mk_op(1'b0, 8'h21, '0, 4'hF));
    exp_q.push_back(mk_op(1'b0, 8'h14, '0, 4'hF));
    rsp_q.push_back(mk_rsp(1'b1, init_val(8'h14)));
    jtag_pulse(1'b0, 8'h00, 1'b0, '0);
    av_access(1'b0, 8'h21, '0, 4'hF, ok, k, rd);
    total++;
    if (!ok || k != 3 || rd !== init_val(8'h21)) begin
      bad++;
      $display("FAIL rr_av_first: got ok=%b wait=%0d data=%h, required 1 3 %h", ok, k, rd, init_val(8'h21));
    end
    check_drained("rr_round2");
  endtask

  task automatic test_debug_priority;
    bit ok; int k; logic [DW-1:0] rd;
    logic [AW-1:0] ja, aa;
    debugack = 1'b1;
    for (int r = 0; r < 2; r++) begin
      ja = AW'(8'h15 + r);
      aa = AW'(8'h22 + r);
      exp_q.push_back(mk_op(1'b0, ja, '0, 4'hF));
      rsp_q.push_back(mk_rsp(1'b1, init_val(ja)));
      exp_q.push_back(mk_op(1'b0, aa, '0, 4'hF));
      jtag_pulse(1'b0, 8'h00, 1'b0, '0);
      av_access(1'b0, aa, '0, 4'hF, ok, k, rd);
      total++;
      if (!ok || k != 7 || rd !== init_val(aa)) begin
        bad++;
        $display("FAIL dbg_jtag_first round %0d: got ok=%b wait=%0d data=%h, required 1 7 %h",
                 r, ok, k, rd, init_val(aa));
      end
      check_drained("dbg_round");
    end
    debugack = 1'b0;
  endtask

  task automatic test_wrap_overrun;
    bit ok;
    exp_q.push_back(mk_op(1'b0, 8'hFF, '0, 4'hF));
    rsp_q.push_back(mk_rsp(1'b1, init_val(8'hFF)));
    jtag_pulse(1'b1, 8'hFF, 1'b0, '0);
    wait_jrsp(ok);
    exp_q.push_back(mk_op(1'b0, 8'h00, '0, 4'hF));
    rsp_q.push_back(mk_rsp(1'b1, init_val(8'h00)));
    jtag_pulse(1'b0, 8'h00, 1'b0, '0);
    wait_jrsp(ok);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL wrap_timeout: got no response, required one");
    end
    check_drained("wrap");
    total++;
    if (jtag_overrun !== 1'b0) begin
      bad++;
      $display("FAIL overrun_pre: got %b, required 0", jtag_overrun);
    end
    // Second strobe arrives while the first is still pending.
    exp_q.push_back(mk_op(1'b1, 8'h01, 32'h11112222, 4'hF));
    rsp_q.push_back(mk_rsp(1'b0, '0));
    @(negedge clk);
    jtag_access = 1'b1; jtag_write = 1'b1; jtag_wdata = 32'h11112222;
    @(negedge clk);
    jtag_wdata = 32'h33334444;
    @(negedge clk);
    jtag_access = 1'b0;
    check_drained("overrun");
    total++;
    if (jtag_overrun !== 1'b1 || mem[8'h01] !== 32'h11112222) begin
      bad++;
      $display("FAIL overrun: got flag=%b mem=%h, required 1 11112222", jtag_overrun, mem[8'h01]);
    end
  endtask

  task automatic test_back_to_back;
    int n = 0;
    int cnt = 0;
    logic [AW-1:0] a = 8'h40;
    for (int i = 0; i < 4; i++) exp_q.push_back(mk_op(1'b0, AW'(8'h40 + i), '0, 4'hF));
    @(negedge clk);
    av_address = a; av_byteenable = 4'hF; av_read = 1'b1;
    for (int t = 0; t < 40 && n < 4; t++) begin
      #1;
      if (av_waitrequest === 1'b0) begin
        total++;
        if (av_readdata !== init_val(a) || (n > 0 && cnt != 4)) begin
          bad++;
          $display("FAIL b2b %0d: got data=%h gap=%0d, required %h 4", n, av_readdata, cnt, init_val(a));
        end
        n++; cnt = 0; a = a + AW'(1);
        if (n == 4) av_read = 1'b0; else av_address = a;
      end
      @(negedge clk);
      cnt++;
    end
    av_read = 1'b0;
    total++;
    if (n != 4) begin
      bad++;
      $display("FAIL b2b_count: got %0d releases, required 4", n);
    end
    check_drained("b2b");
  endtask

  task automatic test_wprot;
    bit ok; int k; logic [DW-1:0] rd;
`ifdef OCI_ARB_WPROT_EN
    exp_q.push_back(mk_op(1'b0, 8'hE4, 32'h55AA55AA, 4'hF));
    @(negedge clk);
    av_access(1'b1, 8'hE4, 32'h55AA55AA, 4'hF, ok, k, rd);
    check_drained("wprot_block");
    total++;
    if (!ok || k != 3 || av_wprot_err !== 1'b1 || mem[8'hE4] !== init_val(8'hE4)) begin
      bad++;
      $display("FAIL wprot_block: got ok=%b wait=%0d err=%b mem=%h, required 1 3 1 %h",
               ok, k, av_wprot_err, mem[8'hE4], init_val(8'hE4));
    end
    debugack = 1'b1;
    exp_q.push_back(mk_op(1'b1, 8'hE4, 32'h55AA55AA, 4'hF));
    @(negedge clk);
    av_access(1'b1, 8'hE4, 32'h55AA55AA, 4'hF, ok, k, rd);
    check_drained("wprot_debug");
    debugack = 1'b0;
    total++;
    if (!ok || k != 3 || mem[8'hE4] !== 32'h55AA55AA || av_wprot_err !== 1'b1) begin
      bad++;
      $display("FAIL wprot_debug: got ok=%b wait=%0d mem=%h err=%b, required 1 3 55aa55aa 1",
               ok, k, mem[8'hE4], av_wprot_err);
    end
`else
    exp_q.push_back(mk_op(1'b1, 8'hE4, 32'h55AA55AA, 4'hF));
    @(negedge clk);
    av_access(1'b1, 8'hE4, 32'h55AA55AA, 4'hF, ok, k, rd);
    check_drained("noprot");
    total++;
    if (!ok || k != 3 || mem[8'hE4] !== 32'h55AA55AA || av_wprot_err !== 1'b0) begin
      bad++;
      $display("FAIL noprot: got ok=%b wait=%0d mem=%h err=%b, required 1 3 55aa55aa 0",
               ok, k, mem[8'hE4], av_wprot_err);
    end
`endif
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = init_val(AW'(i));
    mem[8'h20] = 32'h12345678;
    ram_rdata = '0;
    reset = 1'b1; debugack = 1'b0;
    jtag_addr_load = 1'b0; jtag_addr_in = '0; jtag_access = 1'b0;
    jtag_write = 1'b0; jtag_wdata = '0;
    av_address = '0; av_read = 1'b0; av_write = 1'b0;
    av_writedata = '0; av_byteenable = '0;
    test_reset();
    test_jtag_write();
    test_av_read();
    test_round_robin();
    test_debug_priority();
    test_wrap_overrun();
    test_back_to_back();
    test_wprot();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, required completion");
    $fatal(1);
  end

endmodule

// File: doc/nios2_oci_access_arbiter.md
Name: nios2_oci_access_arbiter

Overview:
- Shares the single-port OCI debug RAM (256x32, 1-cycle read latency) between two requesters: the JTAG debug-slave command path (sysclk-domain take_action strobes plus jdo fields) and the CPU-side Avalon debug_mem slave.
- Sequences each access through a fixed 4-state FSM.
- Owns the JTAG auto-incrementing address register.
- Arbitrates round-robin, or fixed JTAG priority while the CPU sits in debug mode.

Parameters:
ADDR_W, 8, RAM word-address width
DATA_W, 32, RAM data width (byteenable width = DATA_W/8)
PROT_BASE, 8'hE0, first write-protected word address (used only with OCI_ARB_WPROT_EN)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
debugack  in  1  CPU halted in debug; forces JTAG priority
jtag_addr_load  in  1  pulse: load JTAG address register
jtag_addr_in  in  ADDR_W  address loaded on jtag_addr_load
jtag_access  in  1  pulse: request one JTAG RAM access
jtag_write  in  1  JTAG access is a write (sampled with jtag_access)
jtag_wdata  in  DATA_W  JTAG write data (sampled with jtag_access)
jtag_rsp_valid  out  1  1-cycle pulse: JTAG access complete
jtag_rsp_data  out  DATA_W  JTAG read data (MonDReg load value)
jtag_overrun  out  1  sticky: jtag_access dropped while one pending
av_address  in  ADDR_W  Avalon word address
av_read  in  1  Avalon read
av_write  in  1  Avalon write
av_writedata  in  DATA_W  Avalon write data
av_byteenable  in  DATA_W/8  Avalon byte enables
av_waitrequest  out  1  Avalon stall
av_readdata  out  DATA_W  Avalon read data, valid when waitrequest low on a read
av_wprot_err  out  1  sticky protect-violation flag (macro only, else 0)
ram_en  out  1  RAM access strobe
ram_wren  out  1  RAM write enable
ram_addr  out  ADDR_W  RAM address
ram_byteenable  out  DATA_W/8  RAM byte enables
ram_wdata  out  DATA_W  RAM write data
ram_rdata  in  DATA_W  RAM read data, valid the cycle after ram_en

Behaviour:
- Reset values: state=IDLE; all out strobes 0; jtag_addr=0; jtag_pend=0; rdata reg=0; last_owner=AV; sticky flags 0.
- jtag_addr_load loads jtag_addr. If it coincides with jtag_access, the load applies first and the access uses the new address.
- jtag_access with jtag_pend=0: capture write/wdata, set jtag_pend.
- jtag_access with jtag_pend=1: request dropped, jtag_overrun set. The flag clears only on reset.
- av_req = av_read|av_write.
- FSM states:
  - IDLE: if jtag_pend or av_req, pick a winner, register ram_* inputs and owner, go to ISSUE.
  - ISSUE: ram_en=1; ram_wren=write; go to WAIT.
  - WAIT: capture ram_rdata into rdata reg (captured on writes too; ignored); go to DONE.
  - DONE: AV owner drives av_waitrequest=0. JTAG owner drives jtag_rsp_valid=1 and clears jtag_pend. Update last_owner; go to IDLE.
- Latency: 4 cycles from IDLE grant to DONE. Back-to-back accesses every 4 cycles.
- Arbitration when both pend:
  - debugack=1: JTAG wins.
  - Otherwise: the requester that is not last_owner wins.
- JTAG byteenable is all ones.
- jtag_addr increments after each JTAG access (ISSUE cycle), wrapping from 2^ADDR_W-1 to 0.
- av_waitrequest = av_req & ~(DONE & owner==AV). It is combinational, so it is 1 during reset whenever av_req is high.
- av_readdata and jtag_rsp_data come from the rdata reg and hold until the next capture.
- Avalon must hold the request stable while stalled. If av_req drops mid-access, the RAM operation still completes and the FSM returns to IDLE with no error.
- Reset mid-access: the FSM aborts to IDLE and the pending JTAG request is lost. A RAM write already issued in ISSUE is not undone.

Optional Feature:
- Macro: OCI_ARB_WPROT_EN.
- Defined:
  - An Avalon write with ram_addr >= PROT_BASE while debugack=0 still runs all 4 states, but ram_wren is forced to 0 (ram_en stays 1).
  - av_wprot_err is set (sticky until reset).
  - JTAG writes are never blocked.
- Undefined: no protection; av_wprot_err tied 0.

Decomposition:
- Package nios2_oci_arb_pkg: state enum {IDLE, ISSUE, WAIT, DONE}; owner enum {OWN_JTAG, OWN_AV}; ADDR_W/DATA_W defaults.
- Sub-module nios2_oci_arb_jtag_port: JTAG address register, auto-increment, pending/overrun logic.
- Arbitration and FSM stay in the top module.

Test Plan:
- Reset, then jtag_addr_load addr=8'h10, jtag_access write 32'hDEADBEEF -> ram_en+ram_wren at addr 8'h10 in ISSUE; jtag_rsp_valid 3 cycles after grant; jtag_addr=8'h11.
- Preload RAM[8'h20]=32'h12345678; av_read addr 8'h20 -> waitrequest high 3 cycles, low in DONE with av_readdata=32'h12345678.
- jtag_access and av_write assert in the same cycle, debugack=0, after reset -> JTAG granted first, Avalon next; repeat both -> Avalon granted first (alternation).
- Same collision with debugack=1 on every round -> JTAG always granted first.
- jtag_addr=8'hFF, two reads -> addresses 8'hFF then 8'h00. Second jtag_access while pending -> jtag_overrun=1, only one response.
- With OCI_ARB_WPROT_EN: av_write addr 8'hE4, debugack=0 -> ram_wren=0, av_wprot_err=1, waitrequest releases normally. Repeat with debugack=1 -> write occurs.
